// File: rtl/cpu_ula_ctrl_if.sv
// Bus bundle between the ALU sequencer and its neighbours
// (instruction fetch, register file, cpu_ula).
//   master : the sequencer (cpu_ula_ctrl)
//   slave  : the fetch / register-file / ALU side
interface cpu_ula_ctrl_if;
    logic        instr_valid;
    logic [15:0] instr;
    logic        instr_ready;

    logic [2:0]  rf_raddr1;
    logic [2:0]  rf_raddr2;
    logic [15:0] rf_rdata1;
    logic [15:0] rf_rdata2;
    logic        rf_we;
    logic [2:0]  rf_waddr;
    logic [15:0] rf_wdata;

    logic [2:0]  ula_op_code;
    logic [15:0] ula_src1;
    logic [15:0] ula_src2;
    logic [15:0] ula_op_result;
    logic        ula_done;

    logic        busy;
    logic        wb_done;
    logic        err_illegal;
    logic        err_timeout;

    modport master (
        input  instr_valid, instr, rf_rdata1, rf_rdata2, ula_op_result, ula_done,
        output instr_ready, rf_raddr1, rf_raddr2, rf_we, rf_waddr, rf_wdata,
               ula_op_code, ula_src1, ula_src2, busy, wb_done, err_illegal, err_timeout
    );

    modport slave (
        output instr_valid, instr, rf_rdata1, rf_rdata2, ula_op_result, ula_done,
        input  instr_ready, rf_raddr1, rf_raddr2, rf_we, rf_waddr, rf_wdata,
               ula_op_code, ula_src1, ula_src2, busy, wb_done, err_illegal, err_timeout
    );
endinterface

// File: rtl/cpu_ula_ctrl.sv
// Single-issue sequencer: accepts one ALU instruction, reads its operands
// from the register file, strobes cpu_ula for one cycle, waits for done and
// writes the result back. Illegal opcodes and a hung ALU raise one-cycle
// error pulses.
// Ports:
//   clk  - clock, all logic on posedge
//   rst  - synchronous active-high reset
//   bus  - cpu_ula_ctrl_if.master (instruction handshake, RF read/write,
//          ALU operands/strobe/result, status and error pulses)
// Parameter:
//   TIMEOUT - WAIT cycles allowed before abort (3..15)
module cpu_ula_ctrl #(
    parameter int unsigned TIMEOUT = 8
) (
    input  logic           clk,
    input  logic           rst,
    cpu_ula_ctrl_if.master bus
);
    localparam int unsigned CNT_W  = 4;
    localparam int unsigned DATA_W = 16;
    localparam int unsigned IMM_W  = 7;

    localparam logic [2:0] OP_NONE = 3'b000;
    localparam logic [2:0] OP_ADD  = 3'b001;
    localparam logic [2:0] OP_ADDI = 3'b010;
    localparam logic [2:0] OP_SUB  = 3'b011;
    localparam logic [2:0] OP_SUBI = 3'b100;
    localparam logic [2:0] OP_MUL  = 3'b101;

    typedef enum logic [2:0] {
        S_IDLE,
        S_READ,
        S_ISSUE,
        S_WAIT,
        S_WRITE
    } state_t;

    state_t             state;
    logic [2:0]         op_q;
    logic [2:0]         rd_q;
    logic [IMM_W-1:0]   imm_q;
    logic [CNT_W-1:0]   wait_cnt;

    function automatic logic op_legal(input logic [2:0] op);
        return (op == OP_ADD) || (op == OP_ADDI) || (op == OP_SUB) ||
               (op == OP_SUBI) || (op == OP_MUL);
    endfunction

    function automatic logic op_imm(input logic [2:0] op);
        return (op == OP_ADDI) || (op == OP_SUBI);
    endfunction

    // Sequencer; every output is a register updated alongside the state.
    always_ff @(posedge clk) begin
        if (rst) begin
            state           <= S_IDLE;
            op_q            <= OP_NONE;
            rd_q            <= '0;
            imm_q           <= '0;
            wait_cnt        <= '0;
            bus.instr_ready <= 1'b1;
            bus.busy        <= 1'b0;
            bus.rf_raddr1   <= '0;
            bus.rf_raddr2   <= '0;
            bus.rf_we       <= 1'b0;
            bus.rf_waddr    <= '0;
            bus.rf_wdata    <= '0;
            bus.ula_op_code <= OP_NONE;
            bus.ula_src1    <= '0;
            bus.ula_src2    <= '0;
            bus.wb_done     <= 1'b0;
            bus.err_illegal <= 1'b0;
            bus.err_timeout <= 1'b0;
        end else begin
            // strobes default low so each pulse lasts exactly one cycle
            bus.rf_we       <= 1'b0;
            bus.wb_done     <= 1'b0;
            bus.err_illegal <= 1'b0;
            bus.err_timeout <= 1'b0;

            case (state)
                S_IDLE: begin
                    if (bus.instr_valid) begin
                        op_q            <= bus.instr[15:13];
                        rd_q            <= bus.instr[12:10];
                        imm_q           <= bus.instr[6:0];
                        bus.rf_raddr1   <= bus.instr[9:7];
                        bus.rf_raddr2   <= bus.instr[6:4];
                        // decided at acceptance so the pulse lines up with READ
                        bus.err_illegal <= !op_legal(bus.instr[15:13]);
                        bus.instr_ready <= 1'b0;
                        bus.busy        <= 1'b1;
                        state           <= S_READ;
                    end
                end

                S_READ: begin
                    bus.ula_src1 <= bus.rf_rdata1;
                    bus.ula_src2 <= op_imm(op_q) ? {(DATA_W - IMM_W)'(0), imm_q}
                                                 : bus.rf_rdata2;
                    if (!op_legal(op_q)) begin
                        bus.instr_ready <= 1'b1;
                        bus.busy        <= 1'b0;
                        state           <= S_IDLE;
                    end else begin
                        bus.ula_op_code <= op_q;
                        state           <= S_ISSUE;
                    end
                end

                S_ISSUE: begin
                    bus.ula_op_code <= OP_NONE;
                    wait_cnt        <= CNT_W'(1);
                    state           <= S_WAIT;
                end

                S_WAIT: begin
                    // The timeout pulse is committed one edge ahead; a done
                    // arriving in that last WAIT cycle is too late and dropped.
                    if (bus.err_timeout) begin
                        bus.instr_ready <= 1'b1;
                        bus.busy        <= 1'b0;
                        state           <= S_IDLE;
                    end else if (bus.ula_done) begin
                        bus.rf_wdata <= bus.ula_op_result;
                        bus.rf_waddr <= rd_q;
                        bus.rf_we    <= 1'b1;
                        bus.wb_done  <= 1'b1;
                        state        <= S_WRITE;
                    end else begin
                        wait_cnt <= wait_cnt + CNT_W'(1);
                        if (wait_cnt == CNT_W'(TIMEOUT - 1)) begin
                            bus.err_timeout <= 1'b1;
                        end
                    end
                end

                S_WRITE: begin
                    bus.instr_ready <= 1'b1;
                    bus.busy        <= 1'b0;
                    state           <= S_IDLE;
                end

                default: begin
                    bus.instr_ready <= 1'b1;
                    bus.busy        <= 1'b0;
                    bus.ula_op_code <= OP_NONE;
                    state           <= S_IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_cpu_ula_ctrl.sv
// Directed bench for cpu_ula_ctrl with a register-file model and a
// three-stage cpu_ula model (sample, calculate, finish/done).
module tb_cpu_ula_ctrl;
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    cpu_ula_ctrl_if bus_if ();

    cpu_ula_ctrl #(.TIMEOUT(8)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus_if)
    );

    int n_cmp = 0;
    int n_err = 0;

    // register file: combinational reads, preload port has priority
    logic [15:0] rf [8];
    logic        pl_en;
    logic [2:0]  pl_addr;
    logic [15:0] pl_data;
    assign bus_if.rf_rdata1 = rf[bus_if.rf_raddr1];
    assign bus_if.rf_rdata2 = rf[bus_if.rf_raddr2];
    always @(posedge clk) begin
        if (pl_en) rf[pl_addr] <= pl_data;
        else if (bus_if.rf_we) rf[bus_if.rf_waddr] <= bus_if.rf_wdata;
    end

    // ALU model without reset; alu_en=0 models a hung ALU
    logic        alu_en;
    logic        alu_calc = 1'b0;
    logic        alu_done = 1'b0;
    logic [2:0]  alu_op;
    logic [15:0] alu_a, alu_b, alu_res;
    assign bus_if.ula_done      = alu_done;
    assign bus_if.ula_op_result = alu_res;

    function automatic logic [15:0] alu_f(input logic [2:0] op, input logic [15:0] a,
                                          input logic [15:0] b);
        logic [15:0] mag;
        mag = {10'b0, b[5:0]};
        case (op)
            3'b001:  return a + b;
            3'b010:  return b[6] ? a - mag : a + mag;
            3'b011:  return a - b;
            3'b100:  return b[6] ? a + mag : a - mag;
            3'b101:  return a * b;
            default: return 16'h0;
        endcase
    endfunction

    always @(posedge clk) begin
        alu_done <= 1'b0;
        if (alu_calc) begin
            alu_res  <= alu_f(alu_op, alu_a, alu_b);
            alu_done <= alu_en;
        end
        alu_calc <= (bus_if.ula_op_code != 3'b000);
        if (bus_if.ula_op_code != 3'b000) begin
            alu_op <= bus_if.ula_op_code;
            alu_a  <= bus_if.ula_src1;
            alu_b  <= bus_if.ula_src2;
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_cmp++;
        assert (obs === exp)
        else begin
            n_err++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic preload(input logic [2:0] a, input logic [15:0] d);
        pl_en = 1'b1; pl_addr = a; pl_data = d;
        step();
        pl_en = 1'b0;
    endtask

    function automatic logic [15:0] mk(input logic [2:0] op, input logic [2:0] rd,
                                       input logic [2:0] rs1, input logic [6:0] low);
        return {op, rd, rs1, low};
    endfunction

    // Accept at edge 0, check cycles 1..6 of the legal schedule.
    task automatic run_legal(input string tag, input logic [15:0] ins, input logic [2:0] op,
                             input logic [2:0] rd, input logic [15:0] exp_data);
        bus_if.instr = ins; bus_if.instr_valid = 1'b1;
        step();
        bus_if.instr_valid = 1'b0;
        for (int c = 1; c <= 5; c++) begin
            chk({tag, "_op"}, 16'(bus_if.ula_op_code), (c == 2) ? 16'(op) : 16'd0);
            chk({tag, "_busy"}, 16'(bus_if.busy), 16'd1);
            if (c < 5) begin
                chk({tag, "_we_early"}, 16'(bus_if.rf_we), 16'd0);
                step();
            end
        end
        chk({tag, "_we"}, 16'(bus_if.rf_we), 16'd1);
        chk({tag, "_waddr"}, 16'(bus_if.rf_waddr), 16'(rd));
        chk({tag, "_wdata"}, bus_if.rf_wdata, exp_data);
        chk({tag, "_wbdone"}, 16'(bus_if.wb_done), 16'd1);
        step();
        chk({tag, "_ready6"}, 16'(bus_if.instr_ready), 16'd1);
        chk({tag, "_we6"}, 16'(bus_if.rf_we), 16'd0);
        chk({tag, "_wbdone6"}, 16'(bus_if.wb_done), 16'd0);
    endtask

    initial begin
        rst = 1'b1; alu_en = 1'b1; pl_en = 1'b0; pl_addr = '0; pl_data = '0;
        bus_if.instr_valid = 1'b0; bus_if.instr = '0;
        step(); step();
        rst = 1'b0;
        for (int i = 0; i < 8; i++) preload(3'(i), 16'd0);

        // reset state
        chk("rst_ready", 16'(bus_if.instr_ready), 16'd1);
        chk("rst_busy", 16'(bus_if.busy), 16'd0);
        chk("rst_op", 16'(bus_if.ula_op_code), 16'd0);
        chk("rst_src1", bus_if.ula_src1, 16'd0);
        chk("rst_src2", bus_if.ula_src2, 16'd0);
        chk("rst_raddr", {10'b0, bus_if.rf_raddr1, bus_if.rf_raddr2}, 16'd0);
        chk("rst_we", 16'(bus_if.rf_we), 16'd0);
        chk("rst_errs", {14'b0, bus_if.err_illegal, bus_if.err_timeout}, 16'd0);

        // ADD r3 = r1 + r2 = 5 + 7
        preload(3'd1, 16'd5); preload(3'd2, 16'd7);
        run_legal("add", mk(3'b001, 3'd3, 3'd1, {3'd2, 4'b0}), 3'b001, 3'd3, 16'd12);

        // immediates with sign-magnitude imm, r1 = 10
        preload(3'd1, 16'd10);
        run_legal("addi_neg", mk(3'b010, 3'd4, 3'd1, 7'b1000011), 3'b010, 3'd4, 16'd7);
        run_legal("subi_pos", mk(3'b100, 3'd5, 3'd1, 7'b0000011), 3'b100, 3'd5, 16'd7);
        run_legal("subi_neg", mk(3'b100, 3'd6, 3'd1, 7'b1000011), 3'b100, 3'd6, 16'd13);

        // MUL wraps: 300*300 = 90000 -> 24464
        preload(3'd1, 16'd300); preload(3'd2, 16'd300);
        run_legal("mul", mk(3'b101, 3'd7, 3'd1, {3'd2, 4'b0}), 3'b101, 3'd7, 16'd24464);
        chk("rf_r7", rf[7], 16'd24464);

        // illegal opcode 111
        bus_if.instr = mk(3'b111, 3'd1, 3'd1, {3'd2, 4'b0}); bus_if.instr_valid = 1'b1;
        step();
        bus_if.instr_valid = 1'b0;
        chk("ill_err1", 16'(bus_if.err_illegal), 16'd1);
        chk("ill_op1", 16'(bus_if.ula_op_code), 16'd0);
        chk("ill_we1", 16'(bus_if.rf_we), 16'd0);
        step();
        chk("ill_ready2", 16'(bus_if.instr_ready), 16'd1);
        chk("ill_err2", 16'(bus_if.err_illegal), 16'd0);
        chk("ill_op2", 16'(bus_if.ula_op_code), 16'd0);
        chk("ill_we2", 16'(bus_if.rf_we), 16'd0);
        step();
        chk("ill_op3", 16'(bus_if.ula_op_code), 16'd0);

        // timeout with a hung ALU: WAIT cycles 1..8 are cycles 3..10
        alu_en = 1'b0;
        bus_if.instr = mk(3'b001, 3'd3, 3'd1, {3'd2, 4'b0}); bus_if.instr_valid = 1'b1;
        step();
        bus_if.instr_valid = 1'b0;
        for (int c = 1; c <= 10; c++) begin
            chk("to_we", 16'(bus_if.rf_we), 16'd0);
            chk("to_err", 16'(bus_if.err_timeout), (c == 10) ? 16'd1 : 16'd0);
            chk("to_busy", 16'(bus_if.busy), 16'd1);
            step();
        end
        chk("to_ready11", 16'(bus_if.instr_ready), 16'd1);
        chk("to_err11", 16'(bus_if.err_timeout), 16'd0);
        chk("to_rf_r3", rf[3], 16'd12);
        alu_en = 1'b1;
        step();

        // reset during WAIT; the ALU's later done must not write
        bus_if.instr = mk(3'b001, 3'd3, 3'd1, {3'd2, 4'b0}); bus_if.instr_valid = 1'b1;
        step();
        bus_if.instr_valid = 1'b0;
        step(); step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("rw_ready", 16'(bus_if.instr_ready), 16'd1);
        chk("rw_busy", 16'(bus_if.busy), 16'd0);
        chk("rw_src1", bus_if.ula_src1, 16'd0);
        chk("rw_raddr1", 16'(bus_if.rf_raddr1), 16'd0);
        chk("rw_stray_done", 16'(bus_if.ula_done), 16'd1);
        step();
        chk("rw_we", 16'(bus_if.rf_we), 16'd0);
        chk("rw_wbdone", 16'(bus_if.wb_done), 16'd0);
        step();
        chk("rw_rf_r3", rf[3], 16'd12);

        // back-to-back with instr_valid held: A = r1+r2 -> r1, B = r1-r2 -> r2
        preload(3'd1, 16'd20); preload(3'd2, 16'd6);
        bus_if.instr = mk(3'b001, 3'd1, 3'd1, {3'd2, 4'b0}); bus_if.instr_valid = 1'b1;
        step();
        bus_if.instr = mk(3'b011, 3'd2, 3'd1, {3'd2, 4'b0});
        for (int c = 1; c <= 4; c++) begin
            chk("b2b_busyA", 16'(bus_if.busy), 16'd1);
            chk("b2b_raddrA", 16'(bus_if.rf_raddr1), 16'd1);
            step();
        end
        chk("b2b_weA", 16'(bus_if.rf_we), 16'd1);
        chk("b2b_waddrA", 16'(bus_if.rf_waddr), 16'd1);
        chk("b2b_wdataA", bus_if.rf_wdata, 16'd26);
        step();
        chk("b2b_ready6", 16'(bus_if.instr_ready), 16'd1);
        step();
        bus_if.instr_valid = 1'b0;
        chk("b2b_busy7", 16'(bus_if.busy), 16'd1);
        chk("b2b_ready7", 16'(bus_if.instr_ready), 16'd0);
        step(); step(); step(); step();
        chk("b2b_weB", 16'(bus_if.rf_we), 16'd1);
        chk("b2b_waddrB", 16'(bus_if.rf_waddr), 16'd2);
        chk("b2b_wdataB", bus_if.rf_wdata, 16'd20);
        step();
        chk("b2b_ready12", 16'(bus_if.instr_ready), 16'd1);
        chk("b2b_rf_r1", rf[1], 16'd26);
        chk("b2b_rf_r2", rf[2], 16'd20);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
